// File: rtl/nes_joypad_port_if.sv
// Bus between the controller reader / CPU core and one NES joypad port.
// CPU_WR and CPU_RD are single-cycle pulses with no back-pressure; CPU_DOUT is valid every cycle.
interface nes_joypad_port_if;
    logic [15:0] BUTTONS;
    logic        CPU_WR;
    logic        CPU_DIN;
    logic        CPU_RD;
    logic        CPU_DOUT;
    logic [7:0]  NES_BUTTONS;

    modport master (
        output BUTTONS,
        output CPU_WR,
        output CPU_DIN,
        output CPU_RD,
        input  CPU_DOUT,
        input  NES_BUTTONS
    );

    modport slave (
        input  BUTTONS,
        input  CPU_WR,
        input  CPU_DIN,
        input  CPU_RD,
        output CPU_DOUT,
        output NES_BUTTONS
    );
endinterface

// File: rtl/nes_joypad_port.sv
// SNES-to-NES button mapper with turbo, exposed as a $4016-style strobe/serial-read register.
module nes_joypad_port #(
    parameter int   TURBO_HALF = 833333,
    parameter logic FILL_BIT   = 1'b1
) (
    input logic               CLOCK,
    input logic               RESET,
    nes_joypad_port_if.slave  bus
);
    localparam int             CW   = $clog2(TURBO_HALF + 1);
    localparam logic [CW-1:0]  LAST = CW'(TURBO_HALF - 1);

    logic [CW-1:0] r_turbo_cnt;
    logic          r_phase;
    logic [7:0]    r_nes_buttons;
    logic          r_strobe;
    logic [7:0]    r_shift;

    logic [7:0]    w_map;
    logic          w_new_strobe;
    logic          w_unused;

    assign w_unused = ^{bus.BUTTONS[15:10]};

    // Free-running turbo clock; phase flips on every wrap of the counter.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_turbo_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (r_turbo_cnt == LAST) begin
            r_turbo_cnt <= '0;
            r_phase     <= ~r_phase;
        end else begin
            r_turbo_cnt <= r_turbo_cnt + CW'(1);
        end
    end

    always_comb begin
        w_map    = '0;
        w_map[0] = bus.BUTTONS[8] | (bus.BUTTONS[9] & r_phase);
        w_map[1] = bus.BUTTONS[0] | (bus.BUTTONS[1] & r_phase);
        w_map[2] = bus.BUTTONS[2];
        w_map[3] = bus.BUTTONS[3];
        // Opposing directions cancel each other out.
        w_map[4] = bus.BUTTONS[4] & ~bus.BUTTONS[5];
        w_map[5] = bus.BUTTONS[5] & ~bus.BUTTONS[4];
        w_map[6] = bus.BUTTONS[6] & ~bus.BUTTONS[7];
        w_map[7] = bus.BUTTONS[7] & ~bus.BUTTONS[6];
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) r_nes_buttons <= '0;
        else       r_nes_buttons <= w_map;
    end

    assign w_new_strobe = bus.CPU_WR ? bus.CPU_DIN : r_strobe;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET)           r_strobe <= 1'b0;
        else if (bus.CPU_WR) r_strobe <= bus.CPU_DIN;
    end

    // A load whenever either the old or new strobe is high beats a read shift.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET)                          r_shift <= {8{FILL_BIT}};
        else if (r_strobe || w_new_strobe)  r_shift <= r_nes_buttons;
        else if (bus.CPU_RD)                r_shift <= {FILL_BIT, r_shift[7:1]};
    end

    assign bus.CPU_DOUT    = r_shift[0];
    assign bus.NES_BUTTONS = r_nes_buttons;
endmodule

// File: tb/tb_nes_joypad_port.sv
// Directed bench for nes_joypad_port: mapping table, serial readout, turbo, same-cycle WR/RD, reset.
module tb_nes_joypad_port;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    nes_joypad_port_if u_if();

    nes_joypad_port #(.TURBO_HALF(4), .FILL_BIT(1'b1)) dut (
        .CLOCK (clk),
        .RESET (rst),
        .bus   (u_if.slave)
    );

    typedef struct {
        logic [15:0] buttons;
        logic [7:0]  exp_nes;
    } vec_t;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_wr(input logic d);
        u_if.CPU_WR = 1'b1;
        u_if.CPU_DIN = d;
        @(negedge clk);
        u_if.CPU_WR = 1'b0;
    endtask

    task automatic do_rd(output logic v);
        v = u_if.CPU_DOUT;
        u_if.CPU_RD = 1'b1;
        @(negedge clk);
        u_if.CPU_RD = 1'b0;
    endtask

    task automatic do_wr_rd(input logic d, output logic v);
        v = u_if.CPU_DOUT;
        u_if.CPU_WR = 1'b1;
        u_if.CPU_DIN = d;
        u_if.CPU_RD = 1'b1;
        @(negedge clk);
        u_if.CPU_WR = 1'b0;
        u_if.CPU_RD = 1'b0;
    endtask

    task automatic read_n(input int n, output logic [15:0] bits);
        logic v;
        bits = '0;
        for (int i = 0; i < n; i++) begin
            do_rd(v);
            bits[i] = v;
        end
    endtask

    task automatic strobe();
        do_wr(1'b1);
        do_wr(1'b0);
    endtask

    vec_t        vecs[14];
    logic [15:0] bits;
    logic        v;
    logic        samp[24];
    int          last_tr;
    int          n_tr;
    int          n_ones;

    initial begin
        vecs[0]  = '{16'h0000, 8'h00};
        vecs[1]  = '{16'h0109, 8'h0B};
        vecs[2]  = '{16'h0030, 8'h00};
        vecs[3]  = '{16'h00C0, 8'h00};
        vecs[4]  = '{16'h0010, 8'h10};
        vecs[5]  = '{16'h0020, 8'h20};
        vecs[6]  = '{16'h0040, 8'h40};
        vecs[7]  = '{16'h0080, 8'h80};
        vecs[8]  = '{16'h0004, 8'h04};
        vecs[9]  = '{16'h00F0, 8'h00};
        vecs[10] = '{16'h0050, 8'h50};
        vecs[11] = '{16'hFC00, 8'h00};
        vecs[12] = '{16'h0101, 8'h03};
        vecs[13] = '{16'hF1A4, 8'hA5};

        u_if.BUTTONS = '0;
        u_if.CPU_WR  = 1'b0;
        u_if.CPU_DIN = 1'b0;
        u_if.CPU_RD  = 1'b0;
        idle(3);
        chk("reset_dout", {15'd0, u_if.CPU_DOUT}, 16'h0001);
        chk("reset_nes", {8'd0, u_if.NES_BUTTONS}, 16'h0000);
        rst = 1'b0;
        idle(1);
        read_n(2, bits);
        chk("reset_reads_fill", bits, 16'h0003);

        // Basic latch and 10 serial reads: A,B,Sel,Start..., then fill bits.
        u_if.BUTTONS = 16'h0109;
        idle(1);
        strobe();
        read_n(10, bits);
        chk("serial_10_reads", bits, 16'h030B);

        for (int i = 0; i < 14; i++) begin
            u_if.BUTTONS = vecs[i].buttons;
            idle(1);
            chk($sformatf("map_%0d", i), {8'd0, u_if.NES_BUTTONS}, {8'd0, vecs[i].exp_nes});
            strobe();
            read_n(9, bits);
            chk($sformatf("serial_%0d", i), bits, {7'd0, 1'b1, vecs[i].exp_nes});
        end

        // Strobe held high: reads do not advance, and track live buttons.
        u_if.BUTTONS = 16'h0100;
        idle(2);
        do_wr(1'b1);
        idle(1);
        read_n(3, bits);
        chk("strobe_held_reads", bits, 16'h0007);
        u_if.BUTTONS = 16'h0000;
        idle(2);
        do_rd(v);
        chk("strobe_held_release", {15'd0, v}, 16'h0000);
        do_wr(1'b0);

        // Turbo on X: NES A toggles with a 4-cycle half period.
        u_if.BUTTONS = 16'h0200;
        idle(2);
        for (int i = 0; i < 24; i++) begin
            samp[i] = u_if.NES_BUTTONS[0];
            idle(1);
        end
        last_tr = -1;
        n_tr = 0;
        for (int i = 1; i < 24; i++) begin
            if (samp[i] != samp[i-1]) begin
                if (last_tr >= 0) chk("turbo_half_period", 16'(i - last_tr), 16'd4);
                last_tr = i;
                n_tr++;
            end
        end
        chk("turbo_transitions", {15'd0, n_tr >= 5}, 16'h0001);
        u_if.BUTTONS = 16'h0300;
        idle(2);
        n_ones = 0;
        for (int i = 0; i < 12; i++) begin
            if (u_if.NES_BUTTONS[0] === 1'b1) n_ones++;
            idle(1);
        end
        chk("turbo_x_plus_a", 16'(n_ones), 16'd12);

        // Same-cycle WR and RD, plus a redundant WR 0.
        u_if.BUTTONS = 16'h0109;
        idle(2);
        strobe();
        do_wr_rd(1'b0, v);
        chk("wr0_rd_read", {15'd0, v}, 16'h0001);
        do_rd(v);
        chk("wr0_rd_advanced", {15'd0, v}, 16'h0001);
        do_wr(1'b0);
        do_rd(v);
        chk("wr0_idle_no_effect", {15'd0, v}, 16'h0000);
        do_wr_rd(1'b1, v);
        chk("wr1_rd_read", {15'd0, v}, 16'h0001);
        do_wr(1'b0);
        read_n(4, bits);
        chk("wr1_rd_reloaded", bits, 16'h000B);

        // Asynchronous reset part-way through a read sequence.
        u_if.BUTTONS = 16'h0100;
        idle(2);
        strobe();
        read_n(3, bits);
        chk("pre_reset_reads", bits, 16'h0001);
        chk("pre_reset_dout", {15'd0, u_if.CPU_DOUT}, 16'h0000);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_dout", {15'd0, u_if.CPU_DOUT}, 16'h0001);
        chk("async_reset_nes", {8'd0, u_if.NES_BUTTONS}, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        idle(1);
        read_n(3, bits);
        chk("post_reset_fill", bits, 16'h0007);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
